// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen - registered pixel source placed in front of vga_sync.
// Two-stage pipeline: stage 1 registers the pixel and its pattern terms,
// stage 2 selects the active pattern and registers the colour outputs.
// Mode and bouncing-box position change only at frame start (iDE, x=0, y=0).
// Optional overlay: define VGA_PATTERN_CROSSHAIR_EN to force a full-scale
// crosshair through the screen centre in every mode.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CW         = 10,
  parameter int XW         = 10,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [2:0]    iMODE,
  input  logic [XW-1:0] iPX,
  input  logic [XW-1:0] iPY,
  input  logic          iDE,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic [CW-1:0] oRed,
  output logic [CW-1:0] oGreen,
  output logic [CW-1:0] oBlue,
  output logic          oDE,
  output logic [2:0]    oMODE_ACTIVE,
  output logic [15:0]   oFRAME_CNT
);

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_GRAY  = 3'd1,
    MODE_BARS  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_BOX   = 3'd4
  } mode_t;

  localparam int PW  = XW + CW + 16;
  localparam int XW1 = XW + 1;

  localparam logic [CW-1:0] FULL = {CW{1'b1}};

  // Ramp multiplier is rounded up so the right-most active pixel reaches
  // full scale; the product still stays below 2^CW after the >>16.
  localparam logic [63:0] RAMP_NUM   = ((64'd1 << CW) - 64'd1) << 16;
  localparam logic [63:0] RAMP_DEN   = 64'(H_ACTIVE - 1);
  localparam logic [63:0] RAMP_MUL   = (RAMP_NUM + RAMP_DEN - 64'd1) / RAMP_DEN;
  localparam logic [PW-1:0] RAMP_MUL_P = PW'(RAMP_MUL);

  localparam logic [XW-1:0] BAR_W    = XW'(H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR_LAST = XW'(7);
  localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic [XW-1:0] Y_MAX    = XW'(V_ACTIVE - BOX_SIZE);
  localparam logic [XW:0]   BOX_EXT  = XW1'(BOX_SIZE);
  localparam logic [XW-1:0] ONE      = XW'(1);

`ifdef VGA_PATTERN_CROSSHAIR_EN
  localparam logic [XW-1:0] X_MID = XW'(H_ACTIVE / 2);
  localparam logic [XW-1:0] Y_MID = XW'(V_ACTIVE / 2);
`endif

  // frame-level state
  mode_t         mode_q;
  mode_t         mode_in;
  logic [15:0]   frame_cnt;
  logic          frame_start;
  logic [XW-1:0] bx, by, bx_next, by_next;
  logic          dx_neg, dy_neg, dx_neg_next, dy_neg_next;

  // stage 1
  logic [XW-1:0] px1, py1;
  logic          de1;
  logic [CW-1:0] red1, green1, blue1;
  logic [CW-1:0] gray1;
  logic [2:0]    bar1;
  logic          chk1;
  logic [PW-1:0] ramp_prod;
  logic [CW-1:0] gray_c;
  logic [XW-1:0] bar_q;
  logic [2:0]    bar_c;

  // stage 2
  logic          in_box;
  logic [CW-1:0] red_n, green_n, blue_n;

  assign frame_start  = iDE && (iPX == '0) && (iPY == '0);
  assign oMODE_ACTIVE = mode_q;
  assign oFRAME_CNT   = frame_cnt;

  // Fold reserved mode codes 5-7 onto passthrough.
  always_comb begin
    mode_in = MODE_PASS;
    if (iMODE <= 3'd4) mode_in = mode_t'(iMODE);
  end

  // Next box position: step one pixel per frame, bouncing off either edge.
  always_comb begin
    bx_next     = bx;
    by_next     = by;
    dx_neg_next = dx_neg;
    dy_neg_next = dy_neg;
    if (!dx_neg) begin
      if (bx >= X_MAX) begin
        dx_neg_next = 1'b1;
        bx_next     = bx - ONE;
      end else begin
        bx_next = bx + ONE;
      end
    end else begin
      if (bx == '0) begin
        dx_neg_next = 1'b0;
        bx_next     = bx + ONE;
      end else begin
        bx_next = bx - ONE;
      end
    end
    if (!dy_neg) begin
      if (by >= Y_MAX) begin
        dy_neg_next = 1'b1;
        by_next     = by - ONE;
      end else begin
        by_next = by + ONE;
      end
    end else begin
      if (by == '0) begin
        dy_neg_next = 1'b0;
        by_next     = by + ONE;
      end else begin
        by_next = by - ONE;
      end
    end
  end

  // Latch mode, count frames and move the box, only at frame start.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mode_q    <= MODE_PASS;
      frame_cnt <= '0;
      bx        <= '0;
      by        <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
    end else if (frame_start) begin
      mode_q    <= mode_in;
      frame_cnt <= frame_cnt + 16'd1;
      bx        <= bx_next;
      by        <= by_next;
      dx_neg    <= dx_neg_next;
      dy_neg    <= dy_neg_next;
    end
  end

  // Position-only pattern terms, computed ahead of stage 1.
  always_comb begin
    ramp_prod = PW'(iPX) * RAMP_MUL_P;
    gray_c    = CW'(ramp_prod >> 16);
    bar_q     = iPX / BAR_W;
    bar_c     = (bar_q > BAR_LAST) ? 3'd7 : bar_q[2:0];
  end

  // Stage 1: register the pixel, its external colour and pattern terms.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      px1    <= '0;
      py1    <= '0;
      de1    <= 1'b0;
      red1   <= '0;
      green1 <= '0;
      blue1  <= '0;
      gray1  <= '0;
      bar1   <= '0;
      chk1   <= 1'b0;
    end else begin
      px1    <= iPX;
      py1    <= iPY;
      de1    <= iDE;
      red1   <= iRed;
      green1 <= iGreen;
      blue1  <= iBlue;
      gray1  <= gray_c;
      bar1   <= bar_c;
      chk1   <= iPX[CHECK_LOG2] ^ iPY[CHECK_LOG2];
    end
  end

  // Box hit test uses the already-updated box position for the whole frame.
  always_comb begin
    in_box = (px1 >= bx) && ({1'b0, px1} < ({1'b0, bx} + BOX_EXT)) &&
             (py1 >= by) && ({1'b0, py1} < ({1'b0, by} + BOX_EXT));
  end

  // Stage 2 select: blank outside the active area, otherwise pick the pattern.
  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    if (de1) begin
      case (mode_q)
        MODE_GRAY: begin
          red_n   = gray1;
          green_n = gray1;
          blue_n  = gray1;
        end
        MODE_BARS: begin
          red_n   = bar1[1] ? '0 : FULL;
          green_n = bar1[2] ? '0 : FULL;
          blue_n  = bar1[0] ? '0 : FULL;
        end
        MODE_CHECK: begin
          red_n   = chk1 ? FULL : '0;
          green_n = chk1 ? FULL : '0;
          blue_n  = chk1 ? FULL : '0;
        end
        MODE_BOX: begin
          red_n   = in_box ? FULL : red1;
          green_n = in_box ? '0 : green1;
          blue_n  = in_box ? '0 : blue1;
        end
        default: begin
          red_n   = red1;
          green_n = green1;
          blue_n  = blue1;
        end
      endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
      if ((px1 == X_MID) || (py1 == Y_MID)) begin
        red_n   = FULL;
        green_n = FULL;
        blue_n  = FULL;
      end
`endif
    end
  end

  // Stage 2: register the colour outputs and the matching DE.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oDE    <= 1'b0;
    end else begin
      oRed   <= red_n;
      oGreen <= green_n;
      oBlue  <= blue_n;
      oDE    <= de1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen - randomized bench for vga_pattern_gen with a frame-level
// reference model (mode latch, frame count, box walk, per-pixel colour rules).
module tb_vga_pattern_gen;

  localparam int H      = 640;
  localparam int V      = 480;
  localparam int BOX    = 32;
  localparam int BX_MAX = H - BOX;
  localparam int BY_MAX = V - BOX;
  // ramp scale rounded up so x=639 lands on 0x3FF
  localparam longint RAMP_MUL = (longint'(1023) * 65536 + 638) / 639;

  localparam logic [9:0] EXT_R = 10'h123;
  localparam logic [9:0] EXT_G = 10'h2A5;
  localparam logic [9:0] EXT_B = 10'h0F0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [9:0] px, py;
  logic       de;
  logic [9:0] r_in, g_in, b_in;
  logic [9:0] o_r, o_g, o_b;
  logic       o_de;
  logic [2:0] o_mode;
  logic [15:0] o_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_mode, m_cnt, m_bx, m_by, m_dx, m_dy;
  logic [29:0] prev_rgb;
  logic        prev_de;

  bit bar_r [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  bit bar_g [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit bar_b [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  vga_pattern_gen dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iMODE        (mode),
    .iPX          (px),
    .iPY          (py),
    .iDE          (de),
    .iRed         (r_in),
    .iGreen       (g_in),
    .iBlue        (b_in),
    .oRed         (o_r),
    .oGreen       (o_g),
    .oBlue        (o_b),
    .oDE          (o_de),
    .oMODE_ACTIVE (o_mode),
    .oFRAME_CNT   (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [29:0] pack(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    return {r, g, b};
  endfunction

  // colour a DE pixel should get under the model's current mode and box
  function automatic logic [29:0] modelPixel(input int x, input int y, input logic [29:0] ext);
    logic [29:0] c;
    longint p;
    int k;
    logic [9:0] g;
    case (m_mode)
      1: begin
        p = (longint'(x) * RAMP_MUL) >> 16;
        g = p[9:0];
        c = {g, g, g};
      end
      2: begin
        k = x / (H / 8);
        if (k > 7) k = 7;
        c = pack(bar_r[k] ? 10'h3FF : 10'h0, bar_g[k] ? 10'h3FF : 10'h0, bar_b[k] ? 10'h3FF : 10'h0);
      end
      3: c = ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 30'h3FFFFFFF : 30'h0;
      4: begin
        if (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX)
          c = pack(10'h3FF, 10'h0, 10'h0);
        else
          c = ext;
      end
      default: c = ext;
    endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
    if (x == H / 2 || y == V / 2) c = 30'h3FFFFFFF;
`endif
    return c;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_cnt = 0;
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    prev_rgb = '0; prev_de = 1'b0;
  endtask

  // drive one pixel for one clock; check outputs for the previous pixel
  task automatic applyStimulus(input int md, input int x, input int y, input int d,
                               input int r, input int g, input int b);
    logic [29:0] exp_now;
    logic [29:0] ext;
    mode = md[2:0]; px = x[9:0]; py = y[9:0]; de = (d != 0);
    r_in = r[9:0]; g_in = g[9:0]; b_in = b[9:0];
    ext = {r_in, g_in, b_in};
    if (d != 0 && x == 0 && y == 0) begin
      m_mode = (md > 4) ? 0 : md;
      m_cnt  = (m_cnt + 1) & 16'hFFFF;
      if (m_bx + m_dx > BX_MAX || m_bx + m_dx < 0) begin m_bx = m_bx - m_dx; m_dx = -m_dx; end
      else m_bx = m_bx + m_dx;
      if (m_by + m_dy > BY_MAX || m_by + m_dy < 0) begin m_by = m_by - m_dy; m_dy = -m_dy; end
      else m_by = m_by + m_dy;
    end
    exp_now = (d != 0) ? modelPixel(x, y, ext) : 30'h0;
    @(posedge clk);
    #1;
    checkOutput("de", 32'(o_de), 32'(prev_de));
    checkOutput("rgb", 32'({o_r, o_g, o_b}), 32'(prev_rgb));
    checkOutput("mode", 32'(o_mode), 32'(m_mode));
    checkOutput("fcnt", 32'(o_cnt), 32'(m_cnt));
    prev_de  = (d != 0);
    prev_rgb = exp_now;
  endtask

  task automatic doReset();
    rst = 1'b1; de = 1'b0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
    checkOutput("rst_de", 32'(o_de), 32'h0);
    checkOutput("rst_mode", 32'(o_mode), 32'h0);
    checkOutput("rst_fcnt", 32'(o_cnt), 32'h0);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic startFrame(input int md);
    applyStimulus(md, 0, 0, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  // present one DE pixel with fixed external colour, one idle pixel, then
  // compare the output against a fixed expected colour
  task automatic peekPixel(input string tag, input int md, input int x, input int y, input logic [29:0] want);
    applyStimulus(md, x, y, 1, int'(EXT_R), int'(EXT_G), int'(EXT_B));
    applyStimulus(md, 1, 1, 0, 0, 0, 0);
    checkOutput(tag, 32'({o_r, o_g, o_b}), 32'(want));
  endtask

  task automatic randPixel(input int md);
    int d, x, y;
    d = ($urandom_range(0, 3) != 0) ? 1 : 0;
    x = (d != 0) ? $urandom_range(0, H - 1) : $urandom_range(0, 1023);
    y = (d != 0) ? $urandom_range(1, V - 1) : $urandom_range(0, 1023);
    applyStimulus(md, x, y, d, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  initial begin
    int saved_cnt;
    logic [29:0] ext_c;
    logic [29:0] full_c;
    logic [29:0] red_c;
    ext_c  = {EXT_R, EXT_G, EXT_B};
    full_c = 30'h3FFFFFFF;
    red_c  = {10'h3FF, 10'h000, 10'h000};
    mode = '0; px = '0; py = '0; de = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    rst = 1'b1;

    doReset();
    applyStimulus(0, 5, 5, 0, 1, 2, 3);
    applyStimulus(0, 700, 900, 0, 4, 5, 6);

    // gray ramp
    startFrame(1);
    peekPixel("gray_x0", 1, 0, 10, 30'h0);
    peekPixel("gray_x639", 1, 639, 10, full_c);
`ifdef VGA_PATTERN_CROSSHAIR_EN
    peekPixel("gray_x320", 1, 320, 10, full_c);
`else
    peekPixel("gray_x320", 1, 320, 10, {10'd512, 10'd512, 10'd512});
`endif
    repeat (20) randPixel(1);

    // colour bars
    startFrame(2);
    peekPixel("bar_white", 2, 0, 10, full_c);
    peekPixel("bar_yellow", 2, 80, 10, {10'h3FF, 10'h3FF, 10'h000});
    peekPixel("bar_red", 2, 400, 10, red_c);
    peekPixel("bar_black", 2, 639, 10, 30'h0);
    repeat (20) randPixel(2);

    // checker, with a mid-frame request for passthrough
    startFrame(3);
    repeat (20) randPixel(3);
    applyStimulus(0, 100, 200, 1, int'(EXT_R), int'(EXT_G), int'(EXT_B));
    peekPixel("chk_held", 0, 40, 200, full_c);
    checkOutput("mode_held", 32'(o_mode), 32'd3);
    repeat (10) randPixel(0);
    saved_cnt = m_cnt;
    startFrame(0);
    checkOutput("fcnt_step", 32'(o_cnt), 32'((saved_cnt + 1) & 16'hFFFF));
    peekPixel("pass_next", 0, 40, 200, ext_c);

`ifdef VGA_PATTERN_CROSSHAIR_EN
    for (int md = 0; md < 5; md++) begin
      startFrame(md);
      peekPixel("xhair_v", md, 320, 7, full_c);
      peekPixel("xhair_h", md, 5, 240, full_c);
    end
`endif

    // reserved mode code folds to passthrough
    startFrame(2);
    checkOutput("mode_bars", 32'(o_mode), 32'd2);
    startFrame(6);
    checkOutput("mode6_pass", 32'(o_mode), 32'd0);
    repeat (5) randPixel(6);

    // bouncing box from a fresh reset
    doReset();
    for (int f = 1; f <= 620; f++) begin
      startFrame(4);
      if (f == 448) begin
        peekPixel("box_y_edge_in", 4, 448, 448, red_c);
        peekPixel("box_y_edge_out", 4, 480 - 1, 447, ext_c);
      end else if (f == 608) begin
        peekPixel("box_x_edge_in", 4, 608, 288, red_c);
        peekPixel("box_x_edge_out", 4, 607, 288, ext_c);
      end else if (f == 609) begin
        peekPixel("box_x_back_in", 4, 607, 287, red_c);
        peekPixel("box_x_back_out", 4, 639, 287, ext_c);
      end else begin
        applyStimulus(4, m_bx + $urandom_range(0, BOX - 1), m_by + $urandom_range(0, BOX - 1), 1,
                      $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
        randPixel(4);
      end
    end

    // free-running random traffic with random frame starts and mode requests
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        doReset();
        startFrame($urandom_range(0, 7));
      end else if ($urandom_range(0, 39) == 0) begin
        startFrame($urandom_range(0, 7));
      end else begin
        randPixel($urandom_range(0, 7));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
